// File: rtl/booth_csa_reducer_pkg.sv
// Shared types, constants and elaboration helpers for the radix-4 Booth
// multiplier front end (package mul_pkg).
// Optional feature macro: MUL_ACCUM_EN. This package does not depend on it.
package mul_pkg;

  localparam int N_IN  = 32;
  localparam int N_OUT = 2 * N_IN;
  localparam int N_PP  = 17;

  typedef logic [N_OUT-1:0] pp_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_dig_t;

  // Each partial product carries an inverted sign bit at 34+2j. The
  // constant below removes the 2^(34+2j) bias that this adds, summed over
  // all rows and truncated to 64 bits. Rows 15 and 16 put the bias at or
  // above bit 64, so only rows 0..14 contribute.
  localparam pp_t SE_CORR = 64'hAAAA_AAAC_0000_0000;

  // Decodes one overlapping triplet {b[2j+1], b[2j], b[2j-1]} into a digit.
  function automatic booth_dig_t booth_decode(input logic [2:0] t);
    booth_dig_t d;
    case (t)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  // Row count after one level of 3:2 compressors.
  function automatic int csa_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Number of compressor levels needed to get from n rows down to target.
  function automatic int csa_depth(input int n, input int target);
    int m;
    int d;
    m = n;
    d = 0;
    for (int i = 0; i < 16; i++) begin
      if (m > target) begin
        m = csa_next(m);
        d++;
      end
    end
    return d;
  endfunction

  // Row count after lvl compressor levels.
  function automatic int csa_count(input int n, input int lvl);
    int m;
    m = n;
    for (int i = 0; i < lvl; i++) m = csa_next(m);
    return m;
  endfunction

endpackage

// File: rtl/booth_csa_reducer_if.sv
// Operand / redundant-result bus of booth_csa_reducer.
// Optional feature macro: MUL_ACCUM_EN adds the 64-bit addend C.
//
// Handshake: a beat moves on a rising edge where valid && ready. The
// producer holds valid and its data stable until that edge; ready may
// depend combinationally on the downstream ready. The same rule applies
// to in_valid/in_ready and out_valid/out_ready.
interface booth_csa_reducer_if;
  import mul_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] A;
  logic [N_IN-1:0] B;
  logic            is_signed;
`ifdef MUL_ACCUM_EN
  pp_t             C;
`endif
  logic            out_valid;
  logic            out_ready;
  pp_t             Sum;
  pp_t             Carry;
  logic            Ci;

  modport master (
    output in_valid, A, B, is_signed, out_ready,
`ifdef MUL_ACCUM_EN
    output C,
`endif
    input  in_ready, out_valid, Sum, Carry, Ci
  );

  modport slave (
    input  in_valid, A, B, is_signed, out_ready,
`ifdef MUL_ACCUM_EN
    input  C,
`endif
    output in_ready, out_valid, Sum, Carry, Ci
  );

endinterface

// File: rtl/booth_csa_reducer_csa.sv
// One carry-save 3:2 row: bitwise full adders. The carry is returned
// unshifted; the caller moves it up one bit.
module csa_3_2
  import mul_pkg::*;
#(
  parameter int W = N_OUT
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/booth_csa_reducer.sv
// Radix-4 Booth partial-product generator and carry-save reduction tree,
// three register stages, valid/ready on both sides. Produces Sum, Carry
// and Ci with Sum + Carry + Ci == A*B (+ C) mod 2^64.
// Optional feature macro: MUL_ACCUM_EN adds C as one extra tree row.
module booth_csa_reducer
  import mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  booth_csa_reducer_if.slave bus
);

`ifdef MUL_ACCUM_EN
  localparam int ACC_ROWS = 1;
`else
  localparam int ACC_ROWS = 0;
`endif
  // PP rows + packed neg bits + sign-correction constant (+ addend).
  localparam int S2_IN    = N_PP + 2 + ACC_ROWS;
  localparam int S2_DEPTH = csa_depth(S2_IN, 6);
  localparam int S2_OUT   = csa_count(S2_IN, S2_DEPTH);
  localparam int S3_DEPTH = csa_depth(S2_OUT, 2);

  // ---------------- pipeline control ----------------
  logic v1_q, v2_q, v3_q;
  logic en1, en2, en3;

  // A stage loads when it is empty or its contents move on this cycle.
  assign en3 = !v3_q || bus.out_ready;
  assign en2 = !v2_q || en3;
  assign en1 = !v1_q || en2;
  assign bus.in_ready = en1;

  // Valid bits shift whenever their stage loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (en1) v1_q <= bus.in_valid;
      if (en2) v2_q <= v1_q;
      if (en3) v3_q <= v2_q;
    end
  end

  // ---------------- S1: Booth encode and PP select ----------------
  logic [33:0]     a34;
  logic [33:0]     b34;
  logic [34:0]     bx;
  logic [34:0]     pp_d [N_PP];
  logic [N_PP-1:0] neg_d;

  assign a34 = {{2{bus.is_signed & bus.A[N_IN-1]}}, bus.A};
  assign b34 = {{2{bus.is_signed & bus.B[N_IN-1]}}, bus.B};
  assign bx  = {b34, 1'b0};

  for (genvar j = 0; j < N_PP; j++) begin : g_booth
    booth_dig_t  dig;
    logic        neg;
    logic [33:0] mag;
    logic [33:0] p;
    assign dig = booth_decode(bx[2*j+2:2*j]);
    assign neg = (dig == NEG1) || (dig == NEG2);
    assign mag = ((dig == POS1) || (dig == NEG1)) ? a34 :
                 ((dig == POS2) || (dig == NEG2)) ? {a34[32:0], 1'b0} : '0;
    // Negative digits: one's complement here, +1 enters as neg bit at 2j.
    assign p        = neg ? ~mag : mag;
    assign pp_d[j]  = {~p[33], p};
    assign neg_d[j] = neg;
  end

  logic [34:0]     pp_q [N_PP];
  logic [N_PP-1:0] neg_q;
`ifdef MUL_ACCUM_EN
  pp_t             c_q;
`endif

  // S1 data register: unshifted PP rows and digit sign bits.
  always_ff @(posedge clk) begin
    if (en1 && bus.in_valid) begin
      pp_q  <= pp_d;
      neg_q <= neg_d;
`ifdef MUL_ACCUM_EN
      c_q   <= bus.C;
`endif
    end
  end

  // ---------------- S2: first compressor levels ----------------
  pp_t negv;

  // neg_0 goes out as Ci; neg_1..neg_16 share one row since bits 2j never overlap.
  always_comb begin
    negv = '0;
    for (int j = 1; j < N_PP; j++) negv[2*j] = neg_q[j];
  end

  pp_t s2_lvl [S2_DEPTH+1][S2_IN];

  for (genvar j = 0; j < N_PP; j++) begin : g_s2_row
    assign s2_lvl[0][j] = pp_t'(pp_q[j]) << (2 * j);
  end
  assign s2_lvl[0][N_PP]   = negv;
  assign s2_lvl[0][N_PP+1] = SE_CORR;
`ifdef MUL_ACCUM_EN
  assign s2_lvl[0][N_PP+2] = c_q;
`endif

  for (genvar l = 0; l < S2_DEPTH; l++) begin : g_s2_lvl
    localparam int NI = csa_count(S2_IN, l);
    localparam int NC = NI / 3;
    localparam int NO = csa_next(NI);
    for (genvar o = 0; o < S2_IN; o++) begin : g_out
      if ((o < 2 * NC) && ((o % 2) == 0)) begin : g_csa
        pp_t s;
        pp_t c;
        csa_3_2 #(.W(N_OUT)) u_csa (
          .a_i    (s2_lvl[l][3*(o/2)]),
          .b_i    (s2_lvl[l][3*(o/2)+1]),
          .c_i    (s2_lvl[l][3*(o/2)+2]),
          .sum_o  (s),
          .carry_o(c)
        );
        assign s2_lvl[l+1][o]   = s;
        assign s2_lvl[l+1][o+1] = c << 1;
      end else if ((o >= 2 * NC) && (o < NO)) begin : g_pass
        assign s2_lvl[l+1][o] = s2_lvl[l][3*NC + o - 2*NC];
      end else if (o >= NO) begin : g_zero
        assign s2_lvl[l+1][o] = '0;
      end
    end
  end

  pp_t  s2_q [S2_OUT];
  logic ci2_q;

  // S2 data register: at most six partially reduced rows plus Ci.
  always_ff @(posedge clk) begin
    if (en2 && v1_q) begin
      for (int i = 0; i < S2_OUT; i++) s2_q[i] <= s2_lvl[S2_DEPTH][i];
      ci2_q <= neg_q[0];
    end
  end

  // ---------------- S3: reduce to Sum / Carry ----------------
  pp_t s3_lvl [S3_DEPTH+1][S2_OUT];

  for (genvar i = 0; i < S2_OUT; i++) begin : g_s3_row
    assign s3_lvl[0][i] = s2_q[i];
  end

  for (genvar l = 0; l < S3_DEPTH; l++) begin : g_s3_lvl
    localparam int NI = csa_count(S2_OUT, l);
    localparam int NC = NI / 3;
    localparam int NO = csa_next(NI);
    for (genvar o = 0; o < S2_OUT; o++) begin : g_out
      if ((o < 2 * NC) && ((o % 2) == 0)) begin : g_csa
        pp_t s;
        pp_t c;
        csa_3_2 #(.W(N_OUT)) u_csa (
          .a_i    (s3_lvl[l][3*(o/2)]),
          .b_i    (s3_lvl[l][3*(o/2)+1]),
          .c_i    (s3_lvl[l][3*(o/2)+2]),
          .sum_o  (s),
          .carry_o(c)
        );
        assign s3_lvl[l+1][o]   = s;
        assign s3_lvl[l+1][o+1] = c << 1;
      end else if ((o >= 2 * NC) && (o < NO)) begin : g_pass
        assign s3_lvl[l+1][o] = s3_lvl[l][3*NC + o - 2*NC];
      end else if (o >= NO) begin : g_zero
        assign s3_lvl[l+1][o] = '0;
      end
    end
  end

  pp_t  sum_q;
  pp_t  carry_q;
  logic ci3_q;

  // Output register: held while out_valid && !out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      ci3_q   <= 1'b0;
    end else if (en3 && v2_q) begin
      sum_q   <= s3_lvl[S3_DEPTH][0];
      carry_q <= s3_lvl[S3_DEPTH][1];
      ci3_q   <= ci2_q;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.Sum       = sum_q;
  assign bus.Carry     = carry_q;
  assign bus.Ci        = ci3_q;

endmodule
